// File: rtl/decode_execute_stage_reg.sv
// ID->EX pipeline register with stall/flush control, WB write-through into the
// latched operands, and a saturating count of inserted bubbles.
module decode_execute_stage_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_OP_WIDTH   = 4,
  parameter int CTRL_WIDTH     = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      valid_in,
  input  logic [DATA_WIDTH-1:0]     pc_in,
  input  logic [DATA_WIDTH-1:0]     immediate_in,
  input  logic [DATA_WIDTH-1:0]     read_data_1_in,
  input  logic [DATA_WIDTH-1:0]     read_data_2_in,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_in,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_in,
  input  logic [REG_ADDR_WIDTH-1:0] write_register_in,
  input  logic [ALU_OP_WIDTH-1:0]   alu_operation_in,
  input  logic [CTRL_WIDTH-1:0]     ctrl_in,
  input  logic                      write_in,
  input  logic                      wb_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_register_i,
  input  logic [DATA_WIDTH-1:0]     wb_data_i,
  output logic                      valid_out,
  output logic [DATA_WIDTH-1:0]     pc_out,
  output logic [DATA_WIDTH-1:0]     immediate_out,
  output logic [DATA_WIDTH-1:0]     read_data_1_out,
  output logic [DATA_WIDTH-1:0]     read_data_2_out,
  output logic [REG_ADDR_WIDTH-1:0] rs1_out,
  output logic [REG_ADDR_WIDTH-1:0] rs2_out,
  output logic [REG_ADDR_WIDTH-1:0] write_register_out,
  output logic [ALU_OP_WIDTH-1:0]   alu_operation_out,
  output logic [CTRL_WIDTH-1:0]     ctrl_out,
  output logic                      write_out,
  output logic [CNT_WIDTH-1:0]      bubble_count_out
);

  logic                      valid_q, valid_d;
  logic [DATA_WIDTH-1:0]     pc_q, pc_d;
  logic [DATA_WIDTH-1:0]     imm_q, imm_d;
  logic [DATA_WIDTH-1:0]     rd1_q, rd1_d;
  logic [DATA_WIDTH-1:0]     rd2_q, rd2_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_q, rs1_d;
  logic [REG_ADDR_WIDTH-1:0] rs2_q, rs2_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [ALU_OP_WIDTH-1:0]   aluop_q, aluop_d;
  logic [CTRL_WIDTH-1:0]     ctrl_q, ctrl_d;
  logic                      write_q, write_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

  logic wb_nz;
  logic hit1_load, hit2_load, hit1_stall, hit2_stall;
  logic bubble;

  // A WB write to x0 is architecturally discarded, so it must never forward.
  assign wb_nz      = wb_write_i && (wb_register_i != '0);
  assign hit1_load  = wb_nz && (wb_register_i == rs1_in);
  assign hit2_load  = wb_nz && (wb_register_i == rs2_in);
  assign hit1_stall = wb_nz && (wb_register_i == rs1_q);
  assign hit2_stall = wb_nz && (wb_register_i == rs2_q);

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    aluop_d = aluop_q;
    ctrl_d  = ctrl_q;
    write_d = write_q;
    bubble  = 1'b0;

    if (flush_i) begin
      valid_d = 1'b0;
      pc_d    = '0;
      imm_d   = '0;
      rd1_d   = '0;
      rd2_d   = '0;
      rs1_d   = '0;
      rs2_d   = '0;
      rd_d    = '0;
      aluop_d = '0;
      ctrl_d  = '0;
      write_d = 1'b0;
      bubble  = 1'b1;
    end else if (stall_i) begin
      // A held instruction keeps snooping WB so its operands do not go stale.
      if (valid_q && hit1_stall) rd1_d = wb_data_i;
      if (valid_q && hit2_stall) rd2_d = wb_data_i;
    end else begin
      valid_d = valid_in;
      pc_d    = pc_in;
      imm_d   = immediate_in;
      rd1_d   = hit1_load ? wb_data_i : read_data_1_in;
      rd2_d   = hit2_load ? wb_data_i : read_data_2_in;
      rs1_d   = rs1_in;
      rs2_d   = rs2_in;
      rd_d    = write_register_in;
      aluop_d = alu_operation_in;
      ctrl_d  = valid_in ? ctrl_in : '0;
      write_d = write_in && valid_in && (write_register_in != '0);
      bubble  = !valid_in;
    end

    cnt_d = (bubble && (cnt_q != '1)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      imm_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      aluop_q <= '0;
      ctrl_q  <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      aluop_q <= aluop_d;
      ctrl_q  <= ctrl_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_out          = valid_q;
  assign pc_out             = pc_q;
  assign immediate_out      = imm_q;
  assign read_data_1_out    = rd1_q;
  assign read_data_2_out    = rd2_q;
  assign rs1_out            = rs1_q;
  assign rs2_out            = rs2_q;
  assign write_register_out = rd_q;
  assign alu_operation_out  = aluop_q;
  assign ctrl_out           = ctrl_q;
  assign write_out          = write_q;
  assign bubble_count_out   = cnt_q;

endmodule

// File: tb/tb_decode_execute_stage_reg.sv
// Directed bench for the ID->EX stage register (built with a 4-bit bubble counter).
module tb_decode_execute_stage_reg;
  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int AW  = 4;
  localparam int CW  = 4;
  localparam int CNT = 4;

  logic          clk = 1'b0;
  logic          reset, stall_i, flush_i, valid_in, write_in;
  logic [DW-1:0] pc_in, immediate_in, read_data_1_in, read_data_2_in, wb_data_i;
  logic [RW-1:0] rs1_in, rs2_in, write_register_in, wb_register_i;
  logic [AW-1:0] alu_operation_in;
  logic [CW-1:0] ctrl_in;
  logic          wb_write_i;

  logic           valid_out, write_out;
  logic [DW-1:0]  pc_out, immediate_out, read_data_1_out, read_data_2_out;
  logic [RW-1:0]  rs1_out, rs2_out, write_register_out;
  logic [AW-1:0]  alu_operation_out;
  logic [CW-1:0]  ctrl_out;
  logic [CNT-1:0] bubble_count_out;

  int checks   = 0;
  int failures = 0;
  int exp_cnt;

  always #5 clk = ~clk;

  decode_execute_stage_reg #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .ALU_OP_WIDTH(AW),
    .CTRL_WIDTH(CW), .CNT_WIDTH(CNT)
  ) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .valid_in(valid_in), .pc_in(pc_in), .immediate_in(immediate_in),
    .read_data_1_in(read_data_1_in), .read_data_2_in(read_data_2_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .write_register_in(write_register_in),
    .alu_operation_in(alu_operation_in), .ctrl_in(ctrl_in), .write_in(write_in),
    .wb_write_i(wb_write_i), .wb_register_i(wb_register_i), .wb_data_i(wb_data_i),
    .valid_out(valid_out), .pc_out(pc_out), .immediate_out(immediate_out),
    .read_data_1_out(read_data_1_out), .read_data_2_out(read_data_2_out),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .write_register_out(write_register_out),
    .alu_operation_out(alu_operation_out), .ctrl_out(ctrl_out), .write_out(write_out),
    .bubble_count_out(bubble_count_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input string what);
    @(posedge clk);
    #1;
    $display("step %-22s valid=%0b pc=%0h rd1=%0h rd2=%0h wr=%0b ctrl=%0h cnt=%0d",
             what, valid_out, pc_out, read_data_1_out, read_data_2_out,
             write_out, ctrl_out, bubble_count_out);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(valid_out), 32'd0);
    chk({tag, "_pc"},    pc_out, 32'd0);
    chk({tag, "_imm"},   immediate_out, 32'd0);
    chk({tag, "_rd1"},   read_data_1_out, 32'd0);
    chk({tag, "_rd2"},   read_data_2_out, 32'd0);
    chk({tag, "_rs1"},   32'(rs1_out), 32'd0);
    chk({tag, "_rs2"},   32'(rs2_out), 32'd0);
    chk({tag, "_rd"},    32'(write_register_out), 32'd0);
    chk({tag, "_alu"},   32'(alu_operation_out), 32'd0);
    chk({tag, "_ctrl"},  32'(ctrl_out), 32'd0);
    chk({tag, "_write"}, 32'(write_out), 32'd0);
    chk({tag, "_cnt"},   32'(bubble_count_out), 32'd0);
  endtask

  initial begin
    // 1. Reset with random inputs
    reset = 1'b1;
    stall_i = 1'($urandom); flush_i = 1'($urandom); valid_in = 1'($urandom);
    write_in = 1'($urandom); pc_in = $urandom; immediate_in = $urandom;
    read_data_1_in = $urandom; read_data_2_in = $urandom;
    rs1_in = RW'($urandom); rs2_in = RW'($urandom); write_register_in = RW'($urandom);
    alu_operation_in = AW'($urandom); ctrl_in = CW'($urandom);
    wb_write_i = 1'($urandom); wb_register_i = RW'($urandom); wb_data_i = $urandom;
    step("reset1");
    step("reset2");
    chk_all_zero("reset");

    // 2. Plain load
    reset = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    valid_in = 1'b1; write_in = 1'b1; pc_in = 32'h100; immediate_in = 32'h4;
    read_data_1_in = 32'h11; read_data_2_in = 32'h22;
    rs1_in = 5'd3; rs2_in = 5'd4; write_register_in = 5'd5;
    alu_operation_in = 4'd2; ctrl_in = 4'hA; wb_write_i = 1'b0;
    wb_register_i = 5'd3; wb_data_i = 32'hDEAD;
    step("load");
    chk("load_rd1", read_data_1_out, 32'h11);
    chk("load_rd2", read_data_2_out, 32'h22);
    chk("load_valid", 32'(valid_out), 32'd1);
    chk("load_write", 32'(write_out), 32'd1);
    chk("load_pc", pc_out, 32'h100);
    chk("load_imm", immediate_out, 32'h4);
    chk("load_rs1", 32'(rs1_out), 32'd3);
    chk("load_rs2", 32'(rs2_out), 32'd4);
    chk("load_rd", 32'(write_register_out), 32'd5);
    chk("load_alu", 32'(alu_operation_out), 32'd2);
    chk("load_ctrl", 32'(ctrl_out), 32'hA);
    chk("load_cnt", 32'(bubble_count_out), 32'd0);

    // 3. Write-through on load: rs1, then rs2, then x0
    wb_write_i = 1'b1; wb_register_i = 5'd3; wb_data_i = 32'hAA;
    step("wt_rs1");
    chk("wt1_rd1", read_data_1_out, 32'hAA);
    chk("wt1_rd2", read_data_2_out, 32'h22);
    wb_register_i = 5'd4; wb_data_i = 32'hCC;
    step("wt_rs2");
    chk("wt2_rd1", read_data_1_out, 32'h11);
    chk("wt2_rd2", read_data_2_out, 32'hCC);
    rs1_in = 5'd0; wb_register_i = 5'd0; wb_data_i = 32'hAB;
    step("wt_x0");
    chk("wt0_rd1", read_data_1_out, 32'h11);
    chk("wt0_rs1", 32'(rs1_out), 32'd0);

    rs1_in = 5'd3; wb_write_i = 1'b0;
    step("reload");
    chk("reload_rd1", read_data_1_out, 32'h11);

    // 4. Stall 3 cycles; WB writes x3=0xBB in cycle 2
    stall_i = 1'b1; valid_in = 1'b0; write_in = 1'b0; pc_in = 32'h200;
    read_data_1_in = 32'h55; read_data_2_in = 32'h66; ctrl_in = 4'h5;
    step("stall1");
    chk("st1_rd1", read_data_1_out, 32'h11);
    chk("st1_pc", pc_out, 32'h100);
    chk("st1_valid", 32'(valid_out), 32'd1);
    chk("st1_write", 32'(write_out), 32'd1);
    chk("st1_cnt", 32'(bubble_count_out), 32'd0);
    wb_write_i = 1'b1; wb_register_i = 5'd3; wb_data_i = 32'hBB;
    step("stall2");
    chk("st2_rd1", read_data_1_out, 32'hBB);
    chk("st2_rd2", read_data_2_out, 32'h22);
    chk("st2_pc", pc_out, 32'h100);
    wb_write_i = 1'b0;
    step("stall3");
    chk("st3_rd1", read_data_1_out, 32'hBB);
    chk("st3_ctrl", 32'(ctrl_out), 32'hA);
    chk("st3_cnt", 32'(bubble_count_out), 32'd0);

    // 5. Flush with stall, then rd=0 load, then a bubble load
    flush_i = 1'b1; valid_in = 1'b1; write_in = 1'b1;
    step("flush+stall");
    chk("fl_valid", 32'(valid_out), 32'd0);
    chk("fl_write", 32'(write_out), 32'd0);
    chk("fl_ctrl", 32'(ctrl_out), 32'd0);
    chk("fl_rd1", read_data_1_out, 32'd0);
    chk("fl_pc", pc_out, 32'd0);
    chk("fl_cnt", 32'(bubble_count_out), 32'd1);
    flush_i = 1'b0; stall_i = 1'b0; write_register_in = 5'd0;
    step("load_rd0");
    chk("rd0_write", 32'(write_out), 32'd0);
    chk("rd0_valid", 32'(valid_out), 32'd1);
    chk("rd0_ctrl", 32'(ctrl_out), 32'h5);
    chk("rd0_cnt", 32'(bubble_count_out), 32'd1);
    valid_in = 1'b0; write_register_in = 5'd5;
    step("bubble_load");
    chk("bub_write", 32'(write_out), 32'd0);
    chk("bub_ctrl", 32'(ctrl_out), 32'd0);
    chk("bub_valid", 32'(valid_out), 32'd0);
    chk("bub_cnt", 32'(bubble_count_out), 32'd2);
    // stalled bubble must not snoop WB
    stall_i = 1'b1; wb_write_i = 1'b1; wb_register_i = 5'd3; wb_data_i = 32'hEE;
    step("stall_invalid");
    chk("stinv_rd1", read_data_1_out, 32'h55);
    chk("stinv_cnt", 32'(bubble_count_out), 32'd2);

    // 6. Saturation: 19 more bubbles
    stall_i = 1'b0; wb_write_i = 1'b0; valid_in = 1'b0;
    exp_cnt = 2;
    for (int i = 0; i < (1 << CNT) + 3; i++) begin
      step("sat");
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      chk($sformatf("sat_cnt%0d", i), 32'(bubble_count_out), 32'(exp_cnt));
    end

    // Reset during stall and flush
    valid_in = 1'b1; pc_in = 32'h300;
    step("load_pre_reset");
    chk("pre_rst_pc", pc_out, 32'h300);
    stall_i = 1'b1; flush_i = 1'b1; reset = 1'b1;
    step("reset_mid_stall");
    chk_all_zero("rst2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
